i2s_dac_tx: RTL
===============

# i2s_dac_tx

Audio serializer directly downstream of the synthesizer top level. It takes the parallel left/right sample words and the sample-ready strobe. It generates the codec bit clock and LR clock from the audio master clock. It shifts the samples out in standard I2S format: MSB first, one-bit delay, left channel on LRCK low. Its `AUD_DACLRCK` output is the frame trigger that feeds back to the synthesizer's `AUD_DACLRCK` input.

## Interface
- `AUD_BIT_DEPTH`, default 24: sample word width. Legal range 1–31.
- `BCLK_DIV`, default 4: AUDIO_CLK cycles per BCLK period. Must be even and ≥2. 12.288 MHz / 4 / 64 gives 48 kHz.
- `AUDIO_CLK` in 1: the block's only clock.
- `reset_data` in 1: synchronous, active-high reset.
- `lsound_in` in AUD_BIT_DEPTH: left sample, two's complement.
- `rsound_in` in AUD_BIT_DEPTH: right sample, two's complement.
- `sample_ready` in 1: one-cycle strobe, typically driven by the synthesizer's `xxxx_zero`. When high, `lsound_in`/`rsound_in` are valid.
- `mute` in 1: when high at a frame boundary, that frame carries zeros.
- `AUD_BCLK` out 1: bit clock, registered.
- `AUD_DACLRCK` out 1: LR clock, registered. 0 = left slot, 1 = right slot.
- `AUD_DACDAT` out 1: serial data, registered.
- `frame_start` out 1: one-cycle pulse at each frame boundary.
- `underrun` out 1: one-cycle pulse when a frame boundary finds no fresh sample.
- `underrun_cnt` out 16: count of underruns, saturating.

## Operation
- Counters:
  - `div_cnt` runs 0..BCLK_DIV-1 and increments every cycle.
  - `bit_cnt` is 6 bits, 0..63. It increments on the edge where `div_cnt` wraps to 0 (the "BCLK fall edge").
- `AUD_BCLK` is 1 exactly while `div_cnt` is in [BCLK_DIV/2, BCLK_DIV-1]. It rises on the edge where `div_cnt` becomes BCLK_DIV/2 and falls on the BCLK fall edge.
- `AUD_DACLRCK` = `bit_cnt[5]`, updated on the BCLK fall edge. Each frame is 64 BCLK: a 32-bit left slot, then a 32-bit right slot.
- Slot position is `p = bit_cnt[4:0]`. Data bit rules:
  - For p in 1..AUD_BIT_DEPTH: `AUD_DACDAT` = word[AUD_BIT_DEPTH-p]. The word is `frame_l` when `bit_cnt[5]`=0 and `frame_r` otherwise.
  - For any other p: 0. This includes p=0, which is the I2S one-bit delay.
  - `AUD_DACDAT` changes only on the BCLK fall edge, so it is stable while BCLK is high.
- Holding buffer:
  - When `sample_ready`=1, the block captures `lsound_in`/`rsound_in` into `hold_l`/`hold_r` and sets `fresh`=1.
  - A later strobe within the same frame overwrites the buffer. Last-wins; this is not an error.
- Frame boundary is the BCLK fall edge where `bit_cnt` goes 63→0. Actions on that edge:
  - `frame_start` pulses for 1 cycle.
  - If `mute`=1: `frame_l`/`frame_r` ← 0. `fresh` is cleared.
  - Else if `fresh`=1: `frame_l`/`frame_r` ← `hold_l`/`hold_r`. `fresh` ← 0.
  - Else: `frame_l`/`frame_r` keep their value, so the previous sample repeats. `underrun` pulses for 1 cycle and `underrun_cnt` increments, saturating at 0xFFFF.
- `sample_ready` coincident with the boundary: the incoming inputs bypass straight into `frame_l`/`frame_r`, and the holding buffer is loaded as well. `fresh` ends at 0 and there is no underrun. `mute` still takes priority.
- `mute` together with no fresh sample: no underrun is counted.
- Reset takes priority over everything:
  - Reset values: `div_cnt`=0, `bit_cnt`=0, `fresh`=0; `hold_*`, `frame_*`, `underrun_cnt` all 0.
  - All outputs are 0 during reset and on the first cycle after it.
  - Asserting reset mid-frame aborts the frame immediately. The next cycle, all outputs are 0.
  - The first frame after reset transmits zeros.

## Timing
- After reset deasserts:
  - `div_cnt` counts from 0 starting with the next edge.
  - `AUD_BCLK` first rises BCLK_DIV/2 cycles after reset release.
  - The first frame boundary occurs 64·BCLK_DIV cycles after release.
- Latency from `sample_ready` to the MSB on `AUD_DACDAT`:
  - From the next frame boundary, plus 1 BCLK period (the bit-delay slot).
  - From the boundary edge itself, the MSB appears BCLK_DIV cycles later.
- `frame_start`, `underrun` and the `AUD_DACLRCK` 1→0 transition all occur on the same edge.
- All outputs are driven directly from flops. There is no combinational path from any input to any output.
- Throughput: one stereo sample per 64·BCLK_DIV cycles. The synthesizer must strobe `sample_ready` at least once per frame.

## Test plan
- Reset/idle: hold `reset_data` 10 cycles, release, no `sample_ready` → BCLK period 4 cycles (BCLK_DIV=4). LRCK toggles every 128 cycles. DACDAT stays 0. `underrun` pulses at cycle 256 and `underrun_cnt`=1.
- Serialization: strobe L=0x800001, R=0x7FFFFE mid-frame 0 → in frame 1, sampled at BCLK rises:
  - Left bits 1..24 = 1,0×22,1.
  - Right bits = 0,1×22,0.
  - Slot bits 0 and 25..31 = 0.
  - No underrun.
- Bypass: `sample_ready` with L=0x123456 coincident with the boundary edge → that frame carries 0x123456. `fresh`=0 afterward. The next boundary with no strobe flags an underrun and repeats 0x123456.
- Last-wins and mute: two strobes in one frame (0x111111 then 0x222222) → the next frame sends 0x222222. Then `mute`=1 at a boundary → zeros are sent and `underrun_cnt` is unchanged.
- Saturation: force `underrun_cnt`=0xFFFE, run 3 empty frames → the count stops at 0xFFFF and `underrun` pulses each frame.
- Mid-frame reset: assert `reset_data` during left bit 10 → the next cycle all outputs are 0 and the counters restart. The first post-reset frame is all zeros.

Source files
------------

// File: rtl/i2s_dac_tx_if.sv
// Sample-side bus from the synthesizer into the I2S serializer.
// master = synthesizer (drives samples/strobe/mute), slave = serializer.
interface i2s_dac_tx_if #(
  parameter int AUD_BIT_DEPTH = 24
);
  logic [AUD_BIT_DEPTH-1:0] lsound_in;
  logic [AUD_BIT_DEPTH-1:0] rsound_in;
  logic                     sample_ready;
  logic                     mute;

  modport master (
    output lsound_in,
    output rsound_in,
    output sample_ready,
    output mute
  );

  modport slave (
    input lsound_in,
    input rsound_in,
    input sample_ready,
    input mute
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S DAC serializer: BCLK/LRCK generation, 64-BCLK frames, MSB first with one-bit delay.
// MSB leaves BCLK_DIV cycles after a frame boundary; no backpressure, a missing sample repeats the last one.
module i2s_dac_tx #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int BCLK_DIV      = 4
) (
  input  logic               AUDIO_CLK,
  input  logic               reset_data,
  i2s_dac_tx_if.slave        snd,
  output logic               AUD_BCLK,
  output logic               AUD_DACLRCK,
  output logic               AUD_DACDAT,
  output logic               frame_start,
  output logic               underrun,
  output logic [15:0]        underrun_cnt
);
  localparam int                 DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [5:0]         DEPTH    = 6'(AUD_BIT_DEPTH);

  typedef logic [AUD_BIT_DEPTH-1:0] word_t;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  word_t            hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  word_t            frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic             fresh_q, fresh_d;
  logic [15:0]      underrun_cnt_q, underrun_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrck_q, lrck_d;
  logic             dat_q, dat_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;

  logic             fall_edge;
  logic             boundary;
  logic [5:0]       slot_pos;
  word_t            slot_word;
  word_t            slot_shift;

  // Bit clock, slot counter and the serial data bit for the slot about to start.
  always_comb begin
    fall_edge  = (div_cnt_q == DIV_LAST);
    boundary   = fall_edge && (bit_cnt_q == 6'd63);
    div_cnt_d  = fall_edge ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d  = fall_edge ? bit_cnt_q + 6'd1 : bit_cnt_q;
    bclk_d     = (div_cnt_d >= DIV_HALF);
    lrck_d     = fall_edge ? bit_cnt_d[5] : lrck_q;
    slot_pos   = {1'b0, bit_cnt_d[4:0]};
    slot_word  = bit_cnt_d[5] ? frame_r_q : frame_l_q;
    slot_shift = slot_word >> (DEPTH - slot_pos);
    dat_d      = dat_q;
    if (fall_edge) begin
      dat_d = ((slot_pos != 6'd0) && (slot_pos <= DEPTH)) ? slot_shift[0] : 1'b0;
    end
  end

  // Holding buffer and frame latch; mute beats a bypassed or buffered sample.
  always_comb begin
    hold_l_d       = hold_l_q;
    hold_r_d       = hold_r_q;
    fresh_d        = fresh_q;
    frame_l_d      = frame_l_q;
    frame_r_d      = frame_r_q;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    frame_start_d  = boundary;
    if (snd.sample_ready) begin
      hold_l_d = snd.lsound_in;
      hold_r_d = snd.rsound_in;
      fresh_d  = 1'b1;
    end
    if (boundary) begin
      fresh_d = 1'b0;
      if (snd.mute) begin
        frame_l_d = '0;
        frame_r_d = '0;
      end else if (snd.sample_ready) begin
        frame_l_d = snd.lsound_in;
        frame_r_d = snd.rsound_in;
      end else if (fresh_q) begin
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
      end else begin
        underrun_d = 1'b1;
        if (underrun_cnt_q != 16'hFFFF) begin
          underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge AUDIO_CLK) begin
    if (reset_data) begin
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      frame_l_q      <= '0;
      frame_r_q      <= '0;
      fresh_q        <= 1'b0;
      underrun_cnt_q <= '0;
      bclk_q         <= 1'b0;
      lrck_q         <= 1'b0;
      dat_q          <= 1'b0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      frame_l_q      <= frame_l_d;
      frame_r_q      <= frame_r_d;
      fresh_q        <= fresh_d;
      underrun_cnt_q <= underrun_cnt_d;
      bclk_q         <= bclk_d;
      lrck_q         <= lrck_d;
      dat_q          <= dat_d;
      frame_start_q  <= frame_start_d;
      underrun_q     <= underrun_d;
    end
  end

  assign AUD_BCLK     = bclk_q;
  assign AUD_DACLRCK  = lrck_q;
  assign AUD_DACDAT   = dat_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
endmodule
